// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: per-approach light
// codes and the sequencer state encoding.
package traffic_pkg;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_GREEN  = 2'b01;
    localparam logic [1:0] LT_YELLOW = 2'b10;
    localparam logic [1:0] LT_DARK   = 2'b11;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one clk every DIV cycles, in the
// cycle where the count sits at DIV-1. Count restarts at 0 on reset.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count_reg;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (count_reg == CW'(DIV - 1)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == CW'(DIV - 1));

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach round-robin traffic-light sequencer with per-approach request
// latches and request-driven early end of green after the minimum green time.
// Optional macro FLASH_MODE_EN adds the flash input and a flashing-yellow state.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES      = 2,
    parameter int TICK_DIV        = 4,
    parameter int GREEN_TICKS     = 8,
    parameter int MIN_GREEN_TICKS = 3,
    parameter int YELLOW_TICKS    = 2,
    parameter int ALLRED_TICKS    = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PHASES-1:0]         btn,
`ifdef FLASH_MODE_EN
    input  logic                          flash,
`endif
    output logic [2*NUM_PHASES-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
    output logic                          tick
);

    localparam int PW        = $clog2(NUM_PHASES);
    localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_TICKS = (MAX_GY > ALLRED_TICKS) ? MAX_GY : ALLRED_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;

    state_t                state_reg;
    logic [PW-1:0]         phase_reg;
    logic [TW-1:0]         timer_reg;
    logic [NUM_PHASES-1:0] req_reg;
    logic [NUM_PHASES-1:0] req_next;
    logic                  first_reg;   // next green must be phase 0
    logic [PW-1:0]         next_phase;
    logic [PW-1:0]         cand_idx;
    logic                  found;
    logic [PW-1:0]         green_target;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic                  other_req;
    logic                  enter_green;
    logic                  go_flash;
    logic [1:0]            idle_code;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign phase_onehot = NUM_PHASES'(1) << phase_reg;
    assign other_req    = |(req_reg & ~phase_onehot);
    assign green_target = first_reg ? '0 : next_phase;
    assign phase_idx    = phase_reg;

`ifdef FLASH_MODE_EN
    logic dark_reg;
    assign go_flash  = tick & flash;
    assign idle_code = (state_reg == ST_FLASH) ? (dark_reg ? LT_DARK : LT_YELLOW) : LT_RED;
`else
    assign go_flash  = 1'b0;
    assign idle_code = LT_RED;
`endif

    assign enter_green = tick && !go_flash && (state_reg == ST_ALLRED)
                         && (timer_reg == TW'(ALLRED_TICKS - 1));

    // Round-robin pick: first pending request after the current phase.
    always_comb begin
        next_phase = PW'((int'(phase_reg) + 1) % NUM_PHASES);
        cand_idx   = '0;
        found      = 1'b0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            cand_idx = PW'((int'(phase_reg) + k) % NUM_PHASES);
            if (!found && req_reg[cand_idx]) begin
                next_phase = cand_idx;
                found      = 1'b1;
            end
        end
    end

    // Request latch update; the clear on green entry beats a simultaneous press.
    always_comb begin
        req_next = req_reg | (btn & ~((state_reg == ST_GREEN) ? phase_onehot : '0));
        if (enter_green) begin
            req_next = req_next & ~(NUM_PHASES'(1) << green_target);
        end
`ifdef FLASH_MODE_EN
        if (go_flash || state_reg == ST_FLASH) begin
            req_next = '0;
        end
`endif
    end

    // Phase sequencer: advances only on tick edges, timer cleared on each state change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_ALLRED;
            phase_reg <= '0;
            timer_reg <= '0;
            req_reg   <= '0;
            first_reg <= 1'b1;
`ifdef FLASH_MODE_EN
            dark_reg  <= 1'b0;
`endif
        end else begin
            req_reg <= req_next;
            if (tick) begin
                if (go_flash) begin
`ifdef FLASH_MODE_EN
                    if (state_reg != ST_FLASH) begin
                        state_reg <= ST_FLASH;
                        dark_reg  <= 1'b0;
                    end else begin
                        dark_reg  <= ~dark_reg;
                    end
`endif
                    timer_reg <= '0;
                    first_reg <= 1'b1;
                end else begin
                    case (state_reg)
                        ST_ALLRED: begin
                            if (timer_reg == TW'(ALLRED_TICKS - 1)) begin
                                state_reg <= ST_GREEN;
                                phase_reg <= green_target;
                                timer_reg <= '0;
                                first_reg <= 1'b0;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                        ST_GREEN: begin
                            if (timer_reg == TW'(GREEN_TICKS - 1) ||
                                (timer_reg >= TW'(MIN_GREEN_TICKS - 1) && other_req)) begin
                                state_reg <= ST_YELLOW;
                                timer_reg <= '0;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                        ST_YELLOW: begin
                            if (timer_reg == TW'(YELLOW_TICKS - 1)) begin
                                state_reg <= ST_ALLRED;
                                timer_reg <= '0;
                            end else begin
                                timer_reg <= timer_reg + 1'b1;
                            end
                        end
                        default: begin
                            // Leaving flash: full all-red, then phase 0.
                            state_reg <= ST_ALLRED;
                            timer_reg <= '0;
                            first_reg <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Per-approach light decode from registered state.
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_lights
        assign lights[2*gi +: 2] =
            (state_reg == ST_GREEN  && phase_reg == PW'(gi)) ? LT_GREEN  :
            (state_reg == ST_YELLOW && phase_reg == PW'(gi)) ? LT_YELLOW :
            idle_code;
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a 2-approach and a 4-approach
// instance share clock and reset. Outputs are sampled on falling edges; "now"
// counts falling edges since the last reset release (one tick = 4 edges).
// Optional macro FLASH_MODE_EN enables the flash sequence.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] btn2 = '0;
    logic [3:0] btn4 = '0;
    logic       flash = 1'b0;
    logic [3:0] lights2;
    logic [7:0] lights4;
    logic [0:0] phase2;
    logic [1:0] phase4;
    logic       tick2;
    logic       tick4;

    int checks = 0;
    int errors = 0;
    int now = 0;

    always #5 clk = ~clk;

    traffic_phase_controller #(.NUM_PHASES(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn2),
`ifdef FLASH_MODE_EN
        .flash     (flash),
`endif
        .lights    (lights2),
        .phase_idx (phase2),
        .tick      (tick2)
    );

    traffic_phase_controller #(.NUM_PHASES(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn4),
`ifdef FLASH_MODE_EN
        .flash     (1'b0),
`endif
        .lights    (lights4),
        .phase_idx (phase4),
        .tick      (tick4)
    );

    typedef struct {
        int         at;
        logic [3:0] lights;
        logic [0:0] phase;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, now, act, exp);
        end else begin
            $display("ok   %s @%0d: %0h", name, now, act);
        end
    endtask

    task automatic goto(input int k);
        while (now < k) begin
            @(negedge clk);
            now++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        btn2    = '0;
        btn4    = '0;
        flash   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_lights2", 32'(lights2), 32'h0);
        chk("rst_phase2", 32'(phase2), 32'h0);
        chk("rst_tick", 32'(tick2), 32'h0);
        reset_n = 1'b1;
        now = 0;
    endtask

    initial begin
        // Free-running sequence, no buttons: 1 all-red, 8 green, 2 yellow, 1 all-red, phase 1.
        vecs[0] = '{at: 0,  lights: 4'b0000, phase: 1'b0};
        vecs[1] = '{at: 4,  lights: 4'b0001, phase: 1'b0};
        vecs[2] = '{at: 32, lights: 4'b0001, phase: 1'b0};
        vecs[3] = '{at: 36, lights: 4'b0010, phase: 1'b0};
        vecs[4] = '{at: 40, lights: 4'b0010, phase: 1'b0};
        vecs[5] = '{at: 44, lights: 4'b0000, phase: 1'b0};
        vecs[6] = '{at: 48, lights: 4'b0100, phase: 1'b1};
        vecs[7] = '{at: 76, lights: 4'b0100, phase: 1'b1};
        vecs[8] = '{at: 80, lights: 4'b1000, phase: 1'b1};

        // Tick cadence after release: high at edges 3 and 7 only.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            goto(i);
            chk("tick_cadence", 32'(tick2), (i % 4 == 3) ? 32'h1 : 32'h0);
        end

        // Table-driven free-running sequence.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            goto(vecs[i].at);
            chk("seq_lights", 32'(lights2), 32'(vecs[i].lights));
            chk("seq_phase", 32'(phase2), 32'(vecs[i].phase));
        end

        // Reset pulse during phase-1 yellow: immediate reset values, prescaler restarts.
        reset_n = 1'b0;
        goto(81);
        chk("midrst_lights", 32'(lights2), 32'h0);
        chk("midrst_phase", 32'(phase2), 32'h0);
        chk("midrst_tick", 32'(tick2), 32'h0);
        reset_n = 1'b1;
        goto(83);
        chk("midrst_tick_early", 32'(tick2), 32'h0);
        goto(84);
        chk("midrst_tick_first", 32'(tick2), 32'h1);
        chk("midrst_allred", 32'(lights2), 32'h0);
        goto(85);
        chk("midrst_green0", 32'(lights2), 32'h1);

        // Early end by request (2-phase) and two requests in round-robin order (4-phase).
        do_reset();
        goto(8);
        btn2 = 2'b10;
        btn4 = 4'b1100;
        goto(9);
        btn2 = '0;
        btn4 = '0;
        goto(12);
        chk("early_green_t2", 32'(lights2), 32'h1);
        goto(16);
        chk("early_yellow", 32'(lights2), 32'h2);
        chk("p4_yellow0", 32'(lights4), 32'h02);
        goto(24);
        chk("early_allred", 32'(lights2), 32'h0);
        goto(28);
        chk("early_green1", 32'(lights2), 32'h4);
        chk("early_phase1", 32'(phase2), 32'h1);
        chk("p4_green2", 32'(lights4), 32'h10);
        chk("p4_phase2", 32'(phase4), 32'h2);
        goto(36);
        chk("p4_green2_min", 32'(lights4), 32'h10);
        goto(40);
        chk("p4_yellow2", 32'(lights4), 32'h20);
        goto(48);
        chk("p4_allred", 32'(lights4), 32'h00);
        goto(52);
        chk("p4_green3", 32'(lights4), 32'h40);
        chk("p4_phase3", 32'(phase4), 32'h3);
        goto(56);
        chk("req1_cleared_full", 32'(lights2), 32'h4);
        goto(60);
        chk("req1_cleared_yel", 32'(lights2), 32'h8);

        // btn[0] held through its own green: ignored, full green, then phase 1.
        do_reset();
        goto(4);
        btn2 = 2'b01;
        goto(32);
        chk("own_btn_full", 32'(lights2), 32'h1);
        goto(35);
        btn2 = '0;
        goto(36);
        chk("own_btn_yellow", 32'(lights2), 32'h2);
        goto(44);
        chk("own_btn_allred", 32'(lights2), 32'h0);
        goto(48);
        chk("own_btn_next", 32'(lights2), 32'h4);
        chk("own_btn_phase", 32'(phase2), 32'h1);

`ifdef FLASH_MODE_EN
        // Flash during green, then back through all-red to phase 0.
        do_reset();
        goto(8);
        flash = 1'b1;
        goto(12);
        chk("flash_yel", 32'(lights2), 32'hA);
        goto(16);
        chk("flash_dark", 32'(lights2), 32'hF);
        goto(20);
        chk("flash_yel2", 32'(lights2), 32'hA);
        flash = 1'b0;
        goto(24);
        chk("flash_allred", 32'(lights2), 32'h0);
        goto(28);
        chk("flash_green0", 32'(lights2), 32'h1);
        chk("flash_phase0", 32'(phase2), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
